// File: rtl/flex_bus_pkg.sv
// Shared types and constants for the flex parallel register bus.
// Used by the bus master and by slaves that sit on the same bus.
package flex_bus_pkg;

    localparam int FLEX_ADDR_W = 16;
    localparam int FLEX_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } flex_state_e;

    typedef struct packed {
        logic                   write;
        logic [FLEX_ADDR_W-1:0] addr;
        logic [FLEX_DATA_W-1:0] wdata;
    } flex_cmd_t;

    typedef struct packed {
        logic                   timeout;
        logic [FLEX_DATA_W-1:0] rdata;
    } flex_rsp_t;

    // Counter must hold both the setup count and the timeout limit.
    function automatic int flex_cnt_width(input int setup_cycles,
                                          input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        if ($clog2(setup_cycles + 1) > w)
            w = $clog2(setup_cycles + 1);
        if (w < 1)
            w = 1;
        return w;
    endfunction

endpackage

// File: rtl/flex_timeout_cnt.sv
// Clear/enable cycle counter with a last-cycle 'expired' flag.
// 'expired' stays low when limit is 0 (timeout disabled).
module flex_timeout_cnt
    import flex_bus_pkg::*;
#(
    parameter int cnt_width = 8,
    parameter int limit     = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    output logic [cnt_width-1:0] count,
    output logic                 expired
);

    localparam logic [cnt_width-1:0] LAST = cnt_width'(limit - 1);

    // Saturating count of cycles spent in the current state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && (count != '1))
            count <= count + 1'b1;
    end

    assign expired = (limit != 0) && (count == LAST);

endmodule

// File: rtl/flex_bus_master.sv
// Single-outstanding initiator for the flex parallel register bus.
// Converts a valid/ready command into the strobe/trigger/dtack handshake.
module flex_bus_master
    import flex_bus_pkg::*;
#(
    parameter int addr_bus_width = FLEX_ADDR_W,
    parameter int data_bus_width = FLEX_DATA_W,
    parameter int setup_cycles   = 1,
    parameter int timeout_cycles = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [addr_bus_width-1:0] cmd_addr,
    input  logic [data_bus_width-1:0] cmd_wdata,
    output logic                      rsp_valid,
    output logic [data_bus_width-1:0] rsp_rdata,
    output logic                      rsp_timeout,
    output logic [addr_bus_width-1:0] addr,
    output logic [data_bus_width-1:0] data_w,
    output logic                      addr_strobe,
    output logic                      read_trg,
    output logic                      write_trg,
    input  logic [data_bus_width-1:0] data_r,
    input  logic                      data_r_act,
    input  logic                      dtack
);

    localparam int CW = flex_cnt_width(setup_cycles, timeout_cycles);
    localparam logic [CW-1:0] SETUP_LAST = CW'(setup_cycles - 1);

    flex_state_e   state;
    logic          is_write;
    logic          accept;
    logic          leave;
    logic          cnt_en;
    logic [CW-1:0] cnt;
    logic          cnt_expired;
    logic          setup_done;

    assign accept     = cmd_valid & cmd_ready;
    assign setup_done = (cnt == SETUP_LAST);
    assign cnt_en     = (state == ST_SETUP) ||
                        (state == ST_ACCESS) ||
                        (state == ST_RELEASE);

    // Detect the cycle in which the FSM leaves its state, so the counter
    // starts from zero on every state entry.
    always_comb begin
        leave = 1'b0;
        case (state)
            ST_IDLE:    leave = accept;
            ST_SETUP:   leave = setup_done;
            ST_ACCESS:  leave = dtack | cnt_expired;
            ST_RELEASE: leave = ~dtack | cnt_expired;
            ST_DONE:    leave = 1'b1;
            default:    leave = 1'b1;
        endcase
    end

    flex_timeout_cnt #(
        .cnt_width (CW),
        .limit     (timeout_cycles)
    ) u_cnt (
        .clock   (clock),
        .reset   (reset),
        .clear   (leave),
        .enable  (cnt_en),
        .count   (cnt),
        .expired (cnt_expired)
    );

    // Transaction FSM; every bus and response output is registered here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            addr        <= '0;
            data_w      <= '0;
            addr_strobe <= 1'b0;
            read_trg    <= 1'b0;
            write_trg   <= 1'b0;
            is_write    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_SETUP;
                        cmd_ready   <= 1'b0;
                        addr        <= cmd_addr;
                        data_w      <= cmd_wdata;
                        is_write    <= cmd_write;
                        addr_strobe <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (setup_done) begin
                        state     <= ST_ACCESS;
                        read_trg  <= ~is_write;
                        write_trg <= is_write;
                    end
                end
                ST_ACCESS: begin
                    if (dtack) begin
                        state     <= ST_RELEASE;
                        read_trg  <= 1'b0;
                        write_trg <= 1'b0;
                        rsp_rdata <= (!is_write && data_r_act) ? data_r : '0;
                    end else if (cnt_expired) begin
                        state       <= ST_DONE;
                        read_trg    <= 1'b0;
                        write_trg   <= 1'b0;
                        addr_strobe <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (!dtack) begin
                        state       <= ST_DONE;
                        addr_strobe <= 1'b0;
                        rsp_valid   <= 1'b1;
                    end else if (cnt_expired) begin
                        state       <= ST_DONE;
                        addr_strobe <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state       <= ST_IDLE;
                    cmd_ready   <= 1'b1;
                    addr_strobe <= 1'b0;
                    read_trg    <= 1'b0;
                    write_trg   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flex_bus_master.sv
// Randomized bench for flex_bus_master against a flex_out slave model
// (base 0x0040, 4 regs) and a register-array reference model.
module tb_flex_bus_master;
    import flex_bus_pkg::*;

    localparam int AW = FLEX_ADDR_W;
    localparam int DW = FLEX_DATA_W;
    localparam int S  = 1;
    localparam int TO = 255;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_w;
    logic          addr_strobe, read_trg, write_trg;
    logic [DW-1:0] data_r;
    logic          data_r_act, dtack;

    logic          cmd_valid3, cmd_ready3, cmd_write3;
    logic [AW-1:0] cmd_addr3;
    logic [DW-1:0] cmd_wdata3;
    logic          rsp_valid3, rsp_timeout3;
    logic [DW-1:0] rsp_rdata3;
    logic [AW-1:0] addr3;
    logic [DW-1:0] data_w3;
    logic          addr_strobe3, read_trg3, write_trg3;
    logic [DW-1:0] data_r3;
    logic          data_r_act3, dtack3;

    flex_bus_master #(
        .setup_cycles (S),
        .timeout_cycles (TO)
    ) dut (
        .clock (clock), .reset (reset),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
        .cmd_write (cmd_write), .cmd_addr (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .addr (addr), .data_w (data_w),
        .addr_strobe (addr_strobe),
        .read_trg (read_trg), .write_trg (write_trg),
        .data_r (data_r), .data_r_act (data_r_act),
        .dtack (dtack)
    );

    flex_bus_master #(
        .setup_cycles (3),
        .timeout_cycles (TO)
    ) dut3 (
        .clock (clock), .reset (reset),
        .cmd_valid (cmd_valid3), .cmd_ready (cmd_ready3),
        .cmd_write (cmd_write3), .cmd_addr (cmd_addr3),
        .cmd_wdata (cmd_wdata3),
        .rsp_valid (rsp_valid3), .rsp_rdata (rsp_rdata3),
        .rsp_timeout (rsp_timeout3),
        .addr (addr3), .data_w (data_w3),
        .addr_strobe (addr_strobe3),
        .read_trg (read_trg3), .write_trg (write_trg3),
        .data_r (data_r3), .data_r_act (data_r_act3),
        .dtack (dtack3)
    );

    // flex_out slave model: 4 regs at 0x0040, registered one-cycle dtack
    logic [DW-1:0] sl_regs [4];
    logic          stuck;
    logic          sel;

    assign sel        = addr_strobe && (addr >= 16'h0040) && (addr <= 16'h0043);
    assign data_r     = (sel && read_trg) ? sl_regs[addr[1:0]] : '0;
    assign data_r_act = sel && read_trg;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            dtack <= 1'b0;
            for (int i = 0; i < 4; i++) sl_regs[i] <= '0;
        end else begin
            dtack <= (sel && (read_trg || write_trg)) || (stuck && dtack);
            if (sel && write_trg && !dtack) sl_regs[addr[1:0]] <= data_w;
        end
    end

    // simple always-present slave for the setup_cycles=3 instance
    assign data_r3     = 16'hBEEF;
    assign data_r_act3 = read_trg3;
    always @(posedge clock or posedge reset) begin
        if (reset) dtack3 <= 1'b0;
        else       dtack3 <= read_trg3 | write_trg3;
    end

    // bus monitors
    int   trg_rises = 0;
    int   act_cnt   = 0;
    int   rsp_cnt   = 0;
    logic prev_trg  = 1'b0;
    logic both_trg  = 1'b0;
    always @(negedge clock) begin
        if (read_trg && write_trg) both_trg = 1'b1;
        if ((read_trg || write_trg) && !prev_trg) trg_rises++;
        prev_trg = read_trg || write_trg;
        if (data_r_act) act_cnt++;
        if (rsp_valid) rsp_cnt++;
    end

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [DW-1:0] ref_regs [4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic run_cmd(input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d,
                           output logic [DW-1:0] rd, output logic to,
                           output int lat);
        int g;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        g = 0;
        while (!cmd_ready && g < 100) begin
            @(posedge clock); #1; g++;
        end
        chk("ready_before_accept", cmd_ready, 1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 2000) begin
            @(posedge clock); #1; lat++;
        end
        rd = rsp_rdata;
        to = rsp_timeout;
        chk("bus_idle_in_done", {addr_strobe, read_trg, write_trg}, 0);
        @(posedge clock); #1;
        chk("rsp_single_pulse", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    task automatic do_txn(input string tag, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] rd, erd;
        logic          to, eto, mapped;
        int            lat, elat;
        mapped = (a >= 16'h0040) && (a <= 16'h0043);
        run_cmd(wr, a, d, rd, to, lat);
        if (!mapped) begin
            erd  = '0;
            eto  = 1'b1;
            elat = S + TO + 1;
        end else begin
            erd  = wr ? '0 : ref_regs[a[1:0]];
            eto  = stuck;
            elat = stuck ? S + TO + 3 : S + 5;
            if (wr) ref_regs[a[1:0]] = d;
        end
        chk({tag, "_rdata"}, rd, erd);
        chk({tag, "_timeout"}, to, eto);
        chk({tag, "_latency"}, lat, elat);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          wr;
        logic          mapped;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] bx, by;
        logic [DW-1:0] got [3];
        int            acc, nrsp, rises0, act0, rc0, g, n, su;

        reset      = 1'b1;
        stuck      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        cmd_valid3 = 1'b0;
        cmd_write3 = 1'b0;
        cmd_addr3  = '0;
        cmd_wdata3 = '0;
        for (int i = 0; i < 4; i++) ref_regs[i] = '0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, 0);
        chk("rst_bus_ctl", {addr_strobe, read_trg, write_trg}, 0);
        chk("rst_bus_addr_data", {addr, data_w}, 0);
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;

        do_txn("wr_a5c3", 1'b1, 16'h0042, 16'hA5C3);
        chk("slave_reg2", sl_regs[2], 16'hA5C3);

        act0 = act_cnt;
        do_txn("rd_0042", 1'b0, 16'h0042, 16'h0000);
        chk("rd_act_seen", act_cnt > act0, 1);

        do_txn("rd_unmapped", 1'b0, 16'h0100, 16'h0000);

        stuck = 1'b1;
        do_txn("rd_stuck", 1'b0, 16'h0042, 16'h0000);
        stuck = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        do_txn("wr_after_stuck", 1'b1, 16'h0043, 16'h1111);

        // three commands with cmd_valid held high
        bx     = 16'($urandom);
        by     = 16'($urandom);
        rises0 = trg_rises;
        acc    = 0;
        nrsp   = 0;
        cmd_valid = 1'b1;
        fork
            begin
                int gd;
                for (int i = 0; i < 3; i++) begin
                    cmd_write = (i < 2);
                    cmd_addr  = 16'h0040 + 16'(i == 1);
                    cmd_wdata = (i == 0) ? bx : by;
                    gd = 0;
                    while (!cmd_ready && gd < 100) begin
                        @(posedge clock); #1; gd++;
                    end
                    @(posedge clock); #1;
                    acc++;
                end
                cmd_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                while (nrsp < 3 && w < 200) begin
                    @(posedge clock); #1; w++;
                    if (rsp_valid) begin
                        got[nrsp] = rsp_rdata;
                        nrsp++;
                    end
                end
            end
        join
        ref_regs[0] = bx;
        ref_regs[1] = by;
        chk("b2b_accepts", acc, 3);
        chk("b2b_rsp_count", nrsp, 3);
        chk("b2b_trg_rises", trg_rises - rises0, 3);
        chk("b2b_rd_order", got[2], bx);
        chk("b2b_wr_rdata", {got[0], got[1]}, 0);
        chk("b2b_reg1", sl_regs[1], by);
        @(posedge clock); #1;

        for (int i = 0; i < 24; i++) begin
            wr     = 1'($urandom_range(0, 1));
            mapped = ($urandom_range(0, 7) != 0);
            a = mapped ? 16'h0040 + 16'($urandom_range(0, 3))
                       : 16'h0100 + 16'($urandom_range(0, 255));
            d = 16'($urandom);
            do_txn("rand", wr, a, d);
        end

        chk("never_both_trg", both_trg, 0);

        // setup_cycles = 3 instance
        cmd_valid3 = 1'b1;
        cmd_write3 = 1'b0;
        cmd_addr3  = 16'h0010;
        @(posedge clock); #1;
        cmd_valid3 = 1'b0;
        n  = 1;
        su = 0;
        while (!read_trg3 && n < 50) begin
            if (addr_strobe3) su++;
            @(posedge clock); #1; n++;
        end
        chk("setup3_strobe_cycles", su, 3);
        chk("setup3_trg_cycle", n, 4);
        while (!rsp_valid3 && n < 100) begin
            @(posedge clock); #1; n++;
        end
        chk("setup3_latency", n, 3 + 5);
        chk("setup3_rdata", rsp_rdata3, 16'hBEEF);
        @(posedge clock); #1;

        // reset in the middle of an access
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0042;
        g = 0;
        while (!read_trg && g < 50) begin
            @(posedge clock); #1; g++;
        end
        chk("rst_mid_in_access", read_trg, 1);
        @(negedge clock);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        #1;
        chk("rst_mid_bus_ctl", {addr_strobe, read_trg, write_trg}, 0);
        chk("rst_mid_addr", addr, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        rc0 = rsp_cnt;
        @(negedge clock) reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        chk("rst_mid_no_rsp", rsp_cnt - rc0, 0);
        chk("rst_mid_ready_after", cmd_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
